imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Pipelined immediate-decode stage between fetch and decode/execute of the core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its format from the full opcode.
- Outputs the sign-extended XLEN-wide immediate plus format code, one cycle later.
- Generalises the combinational immediate generator to all base formats, XLEN 32/64, a 2-entry skid buffer, and a saturating illegal-opcode counter.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  decoded result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code.
- out_instr  out  32  instruction passed through.
- out_illegal  out  1  unsupported opcode.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.
- cnt_clr  in  1  synchronous clear of illegal_cnt.

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty, out_imm=0, out_fmt=0, out_instr=0, out_illegal=0, illegal_cnt=0. Reset mid-stream discards all held entries.
- Handshake:
  - Transfer occurs when valid&&ready.
  - Latency is 1 cycle: an instruction accepted at edge N is presented at edge N+1 if the output register is free.
  - Output register plus one skid entry; in_ready = !skid_full, registered, with no combinational in→out ready path.
  - If the output is stalled and a new transfer arrives, the transfer goes to the skid entry.
  - When the output drains, the skid entry moves to the output the same cycle.
  - Order is strictly preserved.
  - Output fields stay stable while out_valid && !out_ready.
- Simultaneous accept and drain:
  - With the skid empty, the new result goes directly to the output register.
  - With the skid full, the skid moves to the output and in_ready rises next cycle.
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, Z=6 (CSR zimm), X=7 (illegal).
- Decode on opcode=instr[6:0]:
  - I, imm=sext(instr[31:20]): LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111.
  - OP-IMM-32 0011011: same I rule, legal only when XLEN=64; otherwise X.
  - Shift immediates (OP-IMM/OP-IMM-32, funct3=001/101): imm = zero-extended shamt, instr[24:20] for XLEN 32, instr[25:20] for XLEN 64.
  - S 0100011: sext({instr[31:25],instr[11:7]}).
  - B 1100011: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - U, LUI 0110111 / AUIPC 0010111: sext({instr[31:12],12'b0}); for XLEN 64, bit 31 extends upward.
  - J 1101111: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - R, OP 0110011 (and OP-32 0111011 when XLEN=64): imm=0.
  - SYSTEM 1110011: fmt I, imm=sext(instr[31:20]).
  - Any other opcode, or instr[1:0]!=2'b11: fmt X, out_illegal=1, imm=0.
- Counter:
  - illegal_cnt increments on each accepted illegal instruction and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

Optional Feature:
- Macro IMM_DECODE_ZICSR_EN.
- Defined: SYSTEM with funct3 in {101,110,111} gives fmt Z, imm = zero-extended instr[19:15]. Other funct3 values keep fmt I.
- Undefined: all SYSTEM opcodes give fmt I, and code 6 is never produced.

Decomposition:
- Shared package imm_decode_pkg holds:
  - the opcode localparams;
  - the 3-bit format enum typedef;
  - a typedef for the output payload struct {imm, fmt, instr, illegal}.
- One natural sub-module: imm_skid_buf, a 2-entry valid/ready skid buffer parametrised on payload width, reusable elsewhere in the pipeline.
- Decode logic is a combinational function inside imm_decode_stage feeding the skid buffer.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1.
- SW x2,-4(x1) (0xFE20AE23) → imm=0xFFFFFFFC, fmt=2. BEQ x0,x0,-8 (0xFE000CE3) → imm=0xFFFFFFF8, fmt=3.
- LUI x5,0x12345 (0x123452B7) → imm=0x12345000, fmt=4. JAL x1,+2048 (0x001000EF) → imm=0x00000800, fmt=5. With XLEN=64, LUI 0x80000 → imm=0xFFFFFFFF80000000.
- Back-to-back stream of 3 instructions with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts;
  - the third is held by the source;
  - all 3 emerge in order once out_ready=1;
  - payload is stable while stalled.
- Illegal 0x00000000, then opcode 0x7F → fmt=7, out_illegal=1, illegal_cnt=2. cnt_clr coincident with a third illegal → illegal_cnt=0.
- Assert rst with both entries full → next cycle out_valid=0, in_ready=1, illegal_cnt=0. With the macro defined, CSRRWI (funct3=101, rs1 field=0x1F) → fmt=6, imm=0x1F.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared definitions for the immediate-decode stage: opcode constants,
// instruction format codes and the payload record carried through the skid
// buffer.
package imm_decode_pkg;

    // Widest immediate any build produces; narrower builds use the low bits.
    localparam int IMM_MAX_W = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6,
        FMT_X = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic [31:0]          instr;
        logic                 illegal;
    } imm_payload_t;

    // Sign-extend a 12-bit I-type field to the widest immediate.
    function automatic logic [IMM_MAX_W-1:0] sext12(input logic [11:0] v);
        return {{(IMM_MAX_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready pipeline buffer: one output register plus one skid
// entry. in_ready is a flop output (skid not full), so there is no
// combinational path from out_ready to in_ready. Ordering is strictly FIFO.
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         push;
    logic         pop;

    assign push = in_valid && !skid_valid_q;
    assign pop  = out_valid_q && out_ready;

    // Next-state for the output register and skid entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // Skid full means the output is full too; no push can happen.
            if (pop) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards held entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate-decode stage. Classifies each accepted instruction by
// opcode, produces the sign-extended XLEN immediate and format code one cycle
// later through a two-entry skid buffer, and counts illegal instructions.
// Optional macro IMM_DECODE_ZICSR_EN: SYSTEM funct3 101/110/111 decode as the
// CSR-immediate format (code 6) with the zero-extended rs1 field as immediate.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    localparam int PW = $bits(imm_payload_t);

    // Immediate decode of one raw instruction word; result is full width and
    // truncated to XLEN at the output.
    function automatic imm_payload_t decode(input logic [31:0] instr);
        imm_payload_t         p;
        logic [2:0]           f3;
        logic                 is_shift;
        logic [IMM_MAX_W-1:0] shamt;
        f3       = instr[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        shamt    = (XLEN == 64) ? {{(IMM_MAX_W-6){1'b0}}, instr[25:20]}
                                : {{(IMM_MAX_W-5){1'b0}}, instr[24:20]};
        p.imm     = '0;
        p.fmt     = FMT_X;
        p.instr   = instr;
        p.illegal = 1'b0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_LOAD, OPC_MISC_MEM, OPC_JALR: begin
                    p.fmt = FMT_I;
                    p.imm = sext12(instr[31:20]);
                end
                OPC_OP_IMM: begin
                    p.fmt = FMT_I;
                    p.imm = is_shift ? shamt : sext12(instr[31:20]);
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        p.fmt = FMT_I;
                        p.imm = is_shift ? shamt : sext12(instr[31:20]);
                    end
                end
                OPC_STORE: begin
                    p.fmt = FMT_S;
                    p.imm = sext12({instr[31:25], instr[11:7]});
                end
                OPC_BRANCH: begin
                    p.fmt = FMT_B;
                    p.imm = {{(IMM_MAX_W-13){instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    p.fmt = FMT_U;
                    p.imm = {{(IMM_MAX_W-32){instr[31]}}, instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    p.fmt = FMT_J;
                    p.imm = {{(IMM_MAX_W-21){instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                end
                OPC_OP: begin
                    p.fmt = FMT_R;
                end
                OPC_OP_32: begin
                    if (XLEN == 64) begin
                        p.fmt = FMT_R;
                    end
                end
                OPC_SYSTEM: begin
                    p.fmt = FMT_I;
                    p.imm = sext12(instr[31:20]);
`ifdef IMM_DECODE_ZICSR_EN
                    if (f3[2] && (f3[1:0] != 2'b00)) begin
                        p.fmt = FMT_Z;
                        p.imm = {{(IMM_MAX_W-5){1'b0}}, instr[19:15]};
                    end
`endif
                end
                default: begin
                    p.fmt = FMT_X;
                end
            endcase
        end
        p.illegal = (p.fmt == FMT_X);
        return p;
    endfunction

    imm_payload_t     dec_pl;
    imm_payload_t     out_pl;
    logic [PW-1:0]    out_data;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign dec_pl = decode(in_instr);

    imm_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_pl = out_data;
    assign accept = in_valid && in_ready;

    // Illegal counter next-state: clear wins, increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && dec_pl.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Illegal counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_imm     = out_pl.imm[XLEN-1:0];
    assign out_fmt     = out_pl.fmt;
    assign out_instr   = out_pl.instr;
    assign out_illegal = out_pl.illegal;
    assign illegal_cnt = cnt_q;

    // Upper immediate bits are dropped in narrow builds.
    generate
        if (XLEN < IMM_MAX_W) begin : g_narrow
            logic unused_imm_hi;
            assign unused_imm_hi = ^out_pl.imm[IMM_MAX_W-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: XLEN=32 (16-bit counter) and XLEN=64 (4-bit counter)
// instances share one stimulus stream; a queue-based occupancy model and an
// arithmetic immediate reference provide every expected value.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_instr32;
    logic [2:0]  out_fmt32;
    logic [15:0] cnt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_instr64;
    logic [2:0]  out_fmt64;
    logic [3:0]  cnt64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_instr(out_instr32),
        .out_illegal(out_illegal32), .illegal_cnt(cnt32), .cnt_clr(cnt_clr)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_instr(out_instr64),
        .out_illegal(out_illegal64), .illegal_cnt(cnt64), .cnt_clr(cnt_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint imm;
        int     fmt;
        bit     ill;
    } ref_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt32;
        logic [2:0]  fmt64;
        logic        ill32;
        logic        ill64;
    } vec_t;

    logic [31:0] exp_q[$];
    int          mcnt32 = 0;
    int          mcnt64 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference immediate computed from field weights with plain arithmetic.
    function automatic ref_t ref_decode(input logic [31:0] ins, input bit is64);
        ref_t       r;
        logic [2:0] f3;
        longint     i_imm;
        longint     shamt;
        longint     sgn;
        f3    = ins[14:12];
        i_imm = longint'($signed(ins[31:20]));
        shamt = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
        r.imm = 0;
        r.fmt = 7;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'b0000011, 7'b0001111, 7'b1100111: begin r.fmt = 1; r.imm = i_imm; end
                7'b0010011: begin
                    r.fmt = 1;
                    r.imm = (f3 == 3'd1 || f3 == 3'd5) ? shamt : i_imm;
                end
                7'b0011011: if (is64) begin
                    r.fmt = 1;
                    r.imm = (f3 == 3'd1 || f3 == 3'd5) ? shamt : i_imm;
                end
                7'b0100011: begin
                    r.fmt = 2;
                    r.imm = longint'($signed({ins[31:25], ins[11:7]}));
                end
                7'b1100011: begin
                    sgn   = ins[31] ? -4096 : 0;
                    r.fmt = 3;
                    r.imm = sgn + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                            + longint'(ins[11:8]) * 2;
                end
                7'b0110111, 7'b0010111: begin
                    r.fmt = 4;
                    r.imm = longint'($signed(ins[31:12])) * 4096;
                end
                7'b1101111: begin
                    sgn   = ins[31] ? -1048576 : 0;
                    r.fmt = 5;
                    r.imm = sgn + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                            + longint'(ins[30:21]) * 2;
                end
                7'b0110011: r.fmt = 0;
                7'b0111011: if (is64) r.fmt = 0;
                7'b1110011: begin
                    r.fmt = 1;
                    r.imm = i_imm;
`ifdef IMM_DECODE_ZICSR_EN
                    if (f3 >= 3'd5) begin
                        r.fmt = 6;
                        r.imm = longint'(ins[19:15]);
                    end
`endif
                end
                default: r.fmt = 7;
            endcase
        end
        r.ill = (r.fmt == 7);
        return r;
    endfunction

    // Compare both DUTs with the occupancy model and the head entry reference.
    task automatic check_state();
        ref_t r32, r64;
        chk("out_valid32", out_valid32, exp_q.size() != 0);
        chk("out_valid64", out_valid64, exp_q.size() != 0);
        chk("in_ready32", in_ready32, exp_q.size() < 2);
        chk("in_ready64", in_ready64, exp_q.size() < 2);
        chk("cnt32", cnt32, mcnt32);
        chk("cnt64", cnt64, mcnt64);
        if (exp_q.size() != 0) begin
            r32 = ref_decode(exp_q[0], 1'b0);
            r64 = ref_decode(exp_q[0], 1'b1);
            chk("imm32", out_imm32, r32.imm & 64'hFFFF_FFFF);
            chk("fmt32", out_fmt32, r32.fmt);
            chk("ill32", out_illegal32, r32.ill);
            chk("instr32", out_instr32, exp_q[0]);
            chk("imm64", out_imm64, r64.imm);
            chk("fmt64", out_fmt64, r64.fmt);
            chk("ill64", out_illegal64, r64.ill);
            chk("instr64", out_instr64, exp_q[0]);
        end
    endtask

    // One cycle: check at the negedge, drive, advance the model, next negedge.
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy,
                        input bit clr, output bit acc);
        ref_t r32, r64;
        check_state();
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        cnt_clr   = clr;
        acc = v && (exp_q.size() < 2);
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ins);
        r32 = ref_decode(ins, 1'b0);
        r64 = ref_decode(ins, 1'b1);
        if (clr) begin
            mcnt32 = 0;
            mcnt64 = 0;
        end else if (acc) begin
            if (r32.ill && mcnt32 < 65535) mcnt32++;
            if (r64.ill && mcnt64 < 15) mcnt64++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit v);
        rst = 1'b1;
        in_valid = v;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        mcnt32 = 0;
        mcnt64 = 0;
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] m32,
                                input logic [63:0] m64, input logic [2:0] f32,
                                input logic [2:0] f64);
        vec_t v;
        v.instr = i; v.imm32 = m32; v.imm64 = m64;
        v.fmt32 = f32; v.fmt64 = f64;
        v.ill32 = (f32 == 3'd7); v.ill64 = (f64 == 3'd7);
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [13];
        logic [31:0] w;
        int k;
        opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 16);
        if (k < 13) w[6:0] = opcs[k];
        else if (k == 14) w[1:0] = 2'($urandom_range(0, 2));
        else if (k == 15) w = 32'h0;
        return w;
    endfunction

    vec_t vecs [14];
    bit   acc;
    logic [31:0] held_instr, held_imm;

    initial begin
        vecs[0]  = mk(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1);
        vecs[1]  = mk(32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2);
        vecs[2]  = mk(32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3);
        vecs[3]  = mk(32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4);
        vecs[4]  = mk(32'h001000EF, 32'h00000800, 64'h0000000000000800, 3'd5, 3'd5);
        vecs[5]  = mk(32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4);
        vecs[6]  = mk(32'h002081B3, 32'h0, 64'h0, 3'd0, 3'd0);
        vecs[7]  = mk(32'h00509093, 32'h5, 64'h5, 3'd1, 3'd1);
        vecs[8]  = mk(32'h43F0D093, 32'h1F, 64'h3F, 3'd1, 3'd1);
        vecs[9]  = mk(32'h0010809B, 32'h0, 64'h1, 3'd7, 3'd1);
        vecs[10] = mk(32'h00000000, 32'h0, 64'h0, 3'd7, 3'd7);
        vecs[11] = mk(32'h0000007F, 32'h0, 64'h0, 3'd7, 3'd7);
        vecs[12] = mk(32'h00000073, 32'h0, 64'h0, 3'd1, 3'd1);
`ifdef IMM_DECODE_ZICSR_EN
        vecs[13] = mk(32'h305FD073, 32'h1F, 64'h1F, 3'd6, 3'd6);
`else
        vecs[13] = mk(32'h305FD073, 32'h305, 64'h305, 3'd1, 3'd1);
`endif

        // Reset state
        @(negedge clk);
        do_reset(1'b0);
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_in_ready", in_ready32, 1'b1);
        chk("rst_imm", out_imm32, 32'h0);
        chk("rst_fmt", out_fmt32, 3'd0);
        chk("rst_instr", out_instr32, 32'h0);
        chk("rst_illegal", out_illegal32, 1'b0);
        chk("rst_cnt", cnt32, 16'h0);
        chk("rst_imm64", out_imm64, 64'h0);

        // Table vectors: one-cycle latency with out_ready held high
        for (int i = 0; i < 14; i++) begin
            step(1'b1, vecs[i].instr, 1'b1, 1'b0, acc);
            $display("[TB] vec %0d instr=%h imm32=%h fmt32=%0d imm64=%h fmt64=%0d",
                     i, vecs[i].instr, out_imm32, out_fmt32, out_imm64, out_fmt64);
            chk("vec_valid", out_valid32, 1'b1);
            chk("vec_imm32", out_imm32, vecs[i].imm32);
            chk("vec_fmt32", out_fmt32, vecs[i].fmt32);
            chk("vec_ill32", out_illegal32, vecs[i].ill32);
            chk("vec_imm64", out_imm64, vecs[i].imm64);
            chk("vec_fmt64", out_fmt64, vecs[i].fmt64);
            chk("vec_ill64", out_illegal64, vecs[i].ill64);
            step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        end

        // Stall: three back-to-back, consumer stalled for three cycles
        do_reset(1'b0);
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0, acc);
        step(1'b1, 32'hFE20AE23, 1'b0, 1'b0, acc);
        chk("stall_in_ready_low", in_ready32, 1'b0);
        step(1'b1, 32'hFE000CE3, 1'b0, 1'b0, acc);
        chk("stall_third_held", acc, 1'b0);
        held_instr = out_instr32;
        held_imm   = out_imm32;
        step(1'b1, 32'hFE000CE3, 1'b0, 1'b0, acc);
        chk("stall_instr_stable", out_instr32, held_instr);
        chk("stall_imm_stable", out_imm32, held_imm);
        chk("stall_first_out", out_instr32, 32'hFFF00093);
        step(1'b1, 32'hFE000CE3, 1'b1, 1'b0, acc);
        chk("stall_second_out", out_instr32, 32'hFE20AE23);
        acc = 1'b0;
        for (int n = 0; n < 8 && !acc; n++) step(1'b1, 32'hFE000CE3, 1'b1, 1'b0, acc);
        chk("stall_third_accepted", acc, 1'b1);
        chk("stall_third_out", out_instr32, 32'hFE000CE3);
        $display("[TB] stall sequence done, last out=%h", out_instr32);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Illegal counter and clear priority
        do_reset(1'b0);
        step(1'b1, 32'h00000000, 1'b1, 1'b0, acc);
        chk("ill0_fmt", out_fmt32, 3'd7);
        chk("ill0_flag", out_illegal32, 1'b1);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0, acc);
        chk("ill1_fmt", out_fmt32, 3'd7);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("ill_cnt_two", cnt32, 16'd2);
        step(1'b1, 32'h0000007F, 1'b1, 1'b1, acc);
        chk("ill_clr_wins", cnt32, 16'd0);
        $display("[TB] counter after clear=%0d", cnt32);

        // Saturation of the narrow counter
        for (int n = 0; n < 20; n++) step(1'b1, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("sat_cnt64", cnt64, 4'hF);
        chk("sat_cnt32", cnt32, 16'd20);

        // Reset with both entries full
        step(1'b1, 32'h0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0, 1'b0, 1'b0, acc);
        check_state();
        do_reset(1'b1);
        chk("midrst_out_valid", out_valid32, 1'b0);
        chk("midrst_in_ready", in_ready32, 1'b1);
        chk("midrst_cnt", cnt32, 16'd0);
        chk("midrst_out_valid64", out_valid64, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0, acc);
        end
        for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check_state();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
